// File: rtl/rng_source.sv
// rng_source: pseudo-random digit producer for the index-reduction stage.
//
// A 16-bit Galois LFSR free-runs every clock, so the arrival time of a player
// request adds entropy. On request a 4-bit value already inside the current
// difficulty range is drawn by bounded rejection sampling. The value is
// presented with a one-cycle en strobe, followed by a cool-down gap.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   seed_load   load seed into the LFSR (zero seed becomes SEED); aborts a draw
//   seed[15:0]  seed value
//   req         draw request, level-sampled while idle
//   mode[1:0]   difficulty: 00 -> <4, 01 -> <5, 10 -> <6, 11 -> <16
//   random[3:0] drawn value, held until the next completed draw
//   en          one-cycle strobe, random valid while high
//   busy        high whenever a draw or cool-down is in progress
//   draw_count  number of en pulses issued, wraps at 256
module rng_source #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 8,
  parameter int          DRAW_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        req,
  input  logic [1:0]  mode,
  output logic [3:0]  random,
  output logic        en,
  output logic        busy,
  output logic [7:0]  draw_count
);

  typedef enum logic [1:0] {IDLE, DRAW, GAP} state_t;

  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);
  localparam logic [3:0] GAP_INIT = 4'(DRAW_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_step;
  logic [3:0]  random_q, random_d;
  logic        en_q, en_d;
  logic        busy_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  tries_q, tries_d;
  logic [3:0]  gap_q, gap_d;
  logic [4:0]  limit_q, limit_d;   // 5 bits so that limit 16 is representable
  logic [3:0]  cand;
  logic [4:0]  mode_limit;

  // Galois right shift; taps 0xB400 give a maximal-length sequence, so a
  // non-zero state never reaches zero.
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  // Candidate is taken from the LFSR before this edge's step.
  assign cand      = lfsr_q[3:0];

  always_comb begin
    case (mode)
      2'b00:   mode_limit = 5'd4;
      2'b01:   mode_limit = 5'd5;
      2'b10:   mode_limit = 5'd6;
      default: mode_limit = 5'd16;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_step;
    random_d = random_q;
    en_d     = 1'b0;
    cnt_d    = cnt_q;
    tries_d  = tries_q;
    gap_d    = gap_q;
    limit_d  = limit_q;
    if (seed_load) begin
      // Abandon any draw; random and draw_count are deliberately kept.
      lfsr_d  = (seed == 16'h0000) ? SEED : seed;
      state_d = IDLE;
      tries_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            limit_d = mode_limit;   // frozen for the whole draw
            tries_d = 4'd0;
            state_d = DRAW;
          end
        end
        DRAW: begin
          if ({1'b0, cand} < limit_q) begin
            random_d = cand;
            en_d     = 1'b1;
            cnt_d    = cnt_q + 8'd1;
            gap_d    = GAP_INIT;
            state_d  = GAP;
          end else if (tries_q == TRY_LAST) begin
            // Two low bits are below the smallest limit (4), so always legal.
            random_d = cand & 4'b0011;
            en_d     = 1'b1;
            cnt_d    = cnt_q + 8'd1;
            gap_d    = GAP_INIT;
            state_d  = GAP;
          end else begin
            tries_d = tries_q + 4'd1;
          end
        end
        GAP: begin
          if (gap_q == 4'd0) state_d = IDLE;
          else               gap_d   = gap_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      random_q <= 4'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= 8'd0;
      tries_q  <= 4'd0;
      gap_q    <= 4'd0;
      limit_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      random_q <= random_d;
      en_q     <= en_d;
      busy_q   <= (state_d != IDLE);
      cnt_q    <= cnt_d;
      tries_q  <= tries_d;
      gap_q    <= gap_d;
      limit_q  <= limit_d;
    end
  end

  assign random     = random_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign draw_count = cnt_q;

endmodule

// File: tb/tb_rng_source.sv
// Directed bench for rng_source. Instance a uses default parameters; instance
// b shares all inputs but has MAX_TRIES=1 to exercise the fallback path.
module tb_rng_source;

  logic        clk = 1'b0;
  logic        rst, seed_load, req;
  logic [15:0] seed;
  logic [1:0]  mode;
  logic [3:0]  random_a, random_b;
  logic        en_a, en_b, busy_a, busy_b;
  logic [7:0]  dc_a, dc_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rng_source u_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .mode(mode), .random(random_a), .en(en_a), .busy(busy_a), .draw_count(dc_a)
  );

  rng_source #(.MAX_TRIES(1)) u_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .mode(mode), .random(random_b), .en(en_b), .busy(busy_b), .draw_count(dc_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses, cyc, last, lim;
    rst = 1'b1; seed_load = 1'b0; seed = 16'h0; req = 1'b0; mode = 2'b00;
    tick(); tick();
    chk("rst_random", 32'(random_a), 32'd0);
    chk("rst_en",     32'(en_a),     32'd0);
    chk("rst_busy",   32'(busy_a),   32'd0);
    chk("rst_count",  32'(dc_a),     32'd0);
    rst = 1'b0;

    // Zero seed -> SEED 0xACE1 -> 0xE270; mode 11 accepts candidate 0.
    seed_load = 1'b1; seed = 16'h0000; tick();           // edge 0
    seed_load = 1'b0; req = 1'b1; mode = 2'b11; tick();  // edge 1
    req = 1'b0;
    chk("zs_busy_draw", 32'(busy_a), 32'd1);
    chk("zs_en_early",  32'(en_a),   32'd0);
    tick();                                              // edge 2
    chk("zs_en",     32'(en_a),     32'd1);
    chk("zs_random", 32'(random_a), 32'd0);
    chk("zs_count",  32'(dc_a),     32'd1);
    repeat (5) tick();
    chk("zs_idle", 32'(busy_a), 32'd0);

    // Seed 4: edge1 -> 0x0002, edge 2 accepts 2; then 4 GAP cycles.
    seed_load = 1'b1; seed = 16'h0004; tick();
    seed_load = 1'b0; req = 1'b1; mode = 2'b00; tick();
    req = 1'b0;
    tick();
    chk("s1_en",     32'(en_a),     32'd1);
    chk("s1_random", 32'(random_a), 32'd2);
    chk("s1_count",  32'(dc_a),     32'd2);
    chk("s1_busy",   32'(busy_a),   32'd1);
    tick();
    chk("s1_en_drop", 32'(en_a),   32'd0);
    chk("s1_gap1",    32'(busy_a), 32'd1);
    tick(); tick();
    chk("s1_gap3",    32'(busy_a), 32'd1);
    tick();
    chk("s1_idle",    32'(busy_a), 32'd0);

    // Seed 0xF: 0xB407 (7 rejected) then 0xEE03 (3 accepted). The mode flip
    // after acceptance must not widen the limit. Instance b falls back at edge 2.
    seed_load = 1'b1; seed = 16'h000F; tick();
    seed_load = 1'b0; req = 1'b1; mode = 2'b00; tick();
    req = 1'b0; mode = 2'b11;
    tick();                                              // edge 2
    chk("s2_en_reject", 32'(en_a),     32'd0);
    chk("s2_busy",      32'(busy_a),   32'd1);
    chk("fb_en",        32'(en_b),     32'd1);
    chk("fb_random",    32'(random_b), 32'd3);
    tick();                                              // edge 3
    chk("s2_en",     32'(en_a),     32'd1);
    chk("s2_random", 32'(random_a), 32'd3);
    chk("s2_count",  32'(dc_a),     32'd3);
    chk("fb_en_drop", 32'(en_b),    32'd0);
    repeat (5) tick();
    chk("s2_idle", 32'(busy_a), 32'd0);

    // seed_load while in DRAW (req still high): no strobe, random kept.
    mode = 2'b00;
    seed_load = 1'b1; seed = 16'h0004; tick();
    seed_load = 1'b0; req = 1'b1; tick();                // now in DRAW
    seed_load = 1'b1; seed = 16'h00F0; tick();           // would have accepted 2
    chk("sl_en",     32'(en_a),     32'd0);
    chk("sl_busy",   32'(busy_a),   32'd0);
    chk("sl_random", 32'(random_a), 32'd3);
    chk("sl_count",  32'(dc_a),     32'd3);
    seed_load = 1'b0; req = 1'b0; tick();
    chk("sl_en_after", 32'(en_a), 32'd0);

    // rst during GAP: everything clears.
    seed_load = 1'b1; seed = 16'h0004; tick();
    seed_load = 1'b0; req = 1'b1; tick();
    req = 1'b0; tick();
    chk("rg_en", 32'(en_a), 32'd1);
    chk("rg_count", 32'(dc_a), 32'd4);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rg_busy",   32'(busy_a),   32'd0);
    chk("rg_en_off", 32'(en_a),     32'd0);
    chk("rg_random", 32'(random_a), 32'd0);
    chk("rg_count0", 32'(dc_a),     32'd0);

    // Continuous request: 300 draws, 150 in mode 01 then 150 in mode 10.
    req = 1'b1; mode = 2'b01;
    pulses = 0; cyc = 0; last = -1;
    while (pulses < 300 && cyc < 8000) begin
      tick();
      cyc++;
      if (en_a) begin
        pulses++;
        lim = (pulses <= 150) ? 5 : 6;
        chk("stream_range", 32'(int'(random_a) < lim), 32'd1);
        if (last >= 0) chk("stream_spacing", 32'((cyc - last) >= 6), 32'd1);
        last = cyc;
        chk("stream_count", 32'(dc_a), 32'(pulses % 256));
        if (pulses == 150) mode = 2'b10;
      end
    end
    req = 1'b0;
    chk("stream_done", 32'(pulses), 32'd300);
    chk("count_wrap",  32'(dc_a),   32'd44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
